imem_fetch_unit: RTL and testbench

//   Byte-addressed Y86-64 instruction memory, directly upstream of the Fetch stage.
//   A byte-serial loader port fills memory through a valid/ready handshake.
//   A registered read port returns the 10-byte window at pc (current_instruction) to Fetch.

---
 rtl/imem_fetch_unit.sv | 130 +++++++++++++
 tb/tb_imem_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// Byte-addressed Y86-64 instruction memory: byte-serial loader plus a registered 10-byte fetch window.
// Optional IMEM_BOUNDS_CHECK_EN flags out-of-range windows; otherwise addresses wrap modulo DEPTH.
module imem_fetch_unit #(
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 10,
    parameter int WINDOW_BYTES = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_start,
    input  logic [ADDR_W-1:0]         load_base,
    input  logic                      load_valid,
    input  logic [7:0]                load_byte,
    input  logic                      load_last,
    output logic                      load_ready,
    output logic                      load_done,
    output logic [ADDR_W:0]           load_count,
    input  logic                      rd_en,
    input  logic [63:0]               pc,
    output logic [0:WINDOW_BYTES*8-1] instr,
    output logic                      instr_valid,
    output logic                      imem_error,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W:0]     load_count_reg;
    logic                instr_valid_reg;
    logic                imem_error_reg;
    logic                xfer;
    logic                rd_fire;
    logic                out_of_range;
    logic [7:0]          mem [DEPTH];
    logic [7:0]          window_reg [WINDOW_BYTES];

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load_start) state_next = LOAD;
            LOAD:    if (xfer && load_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        load_done  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                load_done = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign xfer    = load_valid && load_ready;
    assign rd_fire = rd_en && (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            load_count_reg <= '0;
        end else if (state_reg == IDLE && load_start) begin
            wr_ptr_reg     <= load_base;
            load_count_reg <= '0;
        end else if (xfer) begin
            wr_ptr_reg <= (wr_ptr_reg == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (load_count_reg != (ADDR_W + 1)'(DEPTH))
                load_count_reg <= load_count_reg + 1'b1;
        end
    end

    // Memory has no reset so it maps onto RAM; contents survive a reset mid-load.
    always_ff @(posedge clk) begin
        if (xfer) mem[wr_ptr_reg] <= load_byte;
    end

`ifdef IMEM_BOUNDS_CHECK_EN
    logic [63:0] last_addr;
    assign last_addr    = pc + 64'(WINDOW_BYTES - 1);
    assign out_of_range = (pc[63:ADDR_W] != '0) || (last_addr > 64'(DEPTH - 1));
`else
    assign out_of_range = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < WINDOW_BYTES; gi++) begin : g_window
            logic [63:0]       byte_addr;
            logic [ADDR_W-1:0] rd_addr;
            assign byte_addr = pc + 64'(gi);
            assign rd_addr   = ADDR_W'(byte_addr % 64'(DEPTH));

            always_ff @(posedge clk) begin
                if (reset)        window_reg[gi] <= 8'h00;
                else if (rd_fire) window_reg[gi] <= out_of_range ? 8'h00 : mem[rd_addr];
            end

            // Byte pc lands in the most significant slot of the ascending-range bus.
            assign instr[gi*8 +: 8] = window_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid_reg <= 1'b0;
            imem_error_reg  <= 1'b0;
        end else begin
            instr_valid_reg <= rd_fire;
            if (rd_fire) imem_error_reg <= out_of_range;
        end
    end

    assign load_count  = load_count_reg;
    assign instr_valid = instr_valid_reg;
    assign imem_error  = imem_error_reg;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: loads and reads are driven on the falling edge,
// expected windows come from a flat byte-array model and are checked by a separate monitor.
module tb_imem_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [9:0]  load_base;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic [10:0] load_count;
    logic        rd_en;
    logic [63:0] pc;
    logic [0:79] instr;
    logic        instr_valid;
    logic        imem_error;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [7:0]  model [1024];
    logic [80:0] exp_q [$];
    logic [80:0] mon_e;
    logic [7:0]  fixed_bytes [10];
    bit          use_fixed;

    always #5 clk = ~clk;

    imem_fetch_unit dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
        .load_done(load_done), .load_count(load_count),
        .rd_en(rd_en), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .imem_error(imem_error), .busy(busy)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference window: ten consecutive bytes starting at p, most significant first.
    function automatic logic [80:0] expect_window(input logic [63:0] p);
        logic [79:0] d;
        logic        err;
        logic [63:0] a;
        err = 1'b0;
        d   = '0;
`ifdef IMEM_BOUNDS_CHECK_EN
        if (p > 64'd1014) err = 1'b1;
`endif
        if (!err) begin
            for (int i = 0; i < 10; i++) begin
                a = (p + 64'(i)) % 64'd1024;
                d = {d[71:0], model[a[9:0]]};
            end
        end
        return {err, d};
    endfunction

    always @(posedge clk) begin
        #1;
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_instr_valid: got instr %h with no read outstanding", instr);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] read response instr=%h imem_error=%0b", instr, imem_error);
                check("instr", instr, mon_e[79:0]);
                check("imem_error", {79'b0, imem_error}, {79'b0, mon_e[80]});
            end
        end
    end

    task automatic do_read(input logic [63:0] p);
        @(negedge clk);
        rd_en = 1'b1;
        pc    = p;
        exp_q.push_back(expect_window(p));
    endtask

    task automatic rd_idle();
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_load(input int base, input int n, input int gap_pct, input bit rd_during);
        int         sent;
        int         cyc;
        int         wptr;
        int         exp_cnt;
        logic [7:0] b;
        sent    = 0;
        cyc     = 0;
        wptr    = base;
        exp_cnt = (n > 1024) ? 1024 : n;
        @(negedge clk);
        rd_en      = 1'b0;
        load_start = 1'b1;
        load_base  = 10'(base);
        @(negedge clk);
        load_start = 1'b0;
        if (rd_during) begin
            rd_en = 1'b1;
            pc    = 64'(base);
        end
        while (sent < n) begin
            if (cyc > n * 20 + 100) begin
                tests++;
                fails++;
                $display("FAIL load_timeout: sent %0d, required %0d", sent, n);
                break;
            end
            check("busy_during_load", {79'b0, busy}, 80'd1);
            check("load_ready_during_load", {79'b0, load_ready}, 80'd1);
            if ($urandom_range(0, 99) < gap_pct) begin
                load_valid = 1'b0;
                load_last  = 1'b0;
            end else begin
                b          = use_fixed ? fixed_bytes[sent] : 8'($urandom);
                load_valid = 1'b1;
                load_byte  = b;
                load_last  = (sent == n - 1);
                model[wptr] = b;
                wptr = (wptr + 1) % 1024;
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("load_done_pulse", {79'b0, load_done}, 80'd1);
        check("busy_in_done", {79'b0, busy}, 80'd1);
        check("load_ready_in_done", {79'b0, load_ready}, 80'd0);
        check("load_count_done", {69'b0, load_count}, 80'(exp_cnt));
        @(negedge clk);
        check("load_done_once", {79'b0, load_done}, 80'd0);
        check("busy_after_load", {79'b0, busy}, 80'd0);
        check("load_count_hold", {69'b0, load_count}, 80'(exp_cnt));
        $display("[TB] load base=%0d bytes=%0d count=%0d", base, n, load_count);
        if (rd_during) begin
            exp_q.push_back(expect_window(64'(base)));
            @(negedge clk);
            rd_en = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        reset      = 1'b1;
        load_start = 1'b0;
        load_base  = '0;
        load_valid = 1'b0;
        load_byte  = '0;
        load_last  = 1'b0;
        rd_en      = 1'b0;
        pc         = '0;
        use_fixed  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_load_ready", {79'b0, load_ready}, 80'd0);
        check("rst_load_done", {79'b0, load_done}, 80'd0);
        check("rst_load_count", {69'b0, load_count}, 80'd0);
        check("rst_instr", instr, 80'd0);
        check("rst_instr_valid", {79'b0, instr_valid}, 80'd0);
        check("rst_imem_error", {79'b0, imem_error}, 80'd0);
        check("rst_busy", {79'b0, busy}, 80'd0);
        reset = 1'b0;

        // Overlong session fills every byte and wraps over 0..5.
        do_load(0, 1030, 0, 1'b0);
        do_read(64'd0);
        do_read(64'd1020);
        do_read(64'd1014);
        do_read(64'd1015);
        rd_idle();

        fixed_bytes = '{8'h30, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        use_fixed = 1'b1;
        do_load(4, 10, 0, 1'b0);
        use_fixed = 1'b0;
        @(negedge clk);
        rd_en = 1'b1;
        pc    = 64'd4;
        exp_q.push_back({1'b0, 80'h30F2_0000_0000_0000_0002});
        rd_idle();

        do_load(100, 1, 0, 1'b0);
        do_read(64'd100);
        rd_idle();

        for (int t = 0; t < 6; t++) begin
            base = $urandom_range(0, 1023);
            n    = $urandom_range(2, 30);
            do_load(base, n, 40, t[0]);
            for (int k = 0; k < n; k++) do_read(64'((base + k) % 1024));
            rd_idle();
        end

        // Reset after 3 of 8 bytes: written bytes stay, no done pulse.
        @(negedge clk);
        load_start = 1'b1;
        load_base  = 10'd500;
        @(negedge clk);
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_byte  = 8'($urandom);
            load_last  = 1'b0;
            model[500 + k] = load_byte;
            @(negedge clk);
        end
        load_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {79'b0, busy}, 80'd0);
        check("midrst_load_ready", {79'b0, load_ready}, 80'd0);
        check("midrst_load_done", {79'b0, load_done}, 80'd0);
        check("midrst_load_count", {69'b0, load_count}, 80'd0);
        @(negedge clk);
        check("midrst_no_done", {79'b0, load_done}, 80'd0);
        $display("[TB] reset mid-load at base 500 after 3 bytes");
        for (int k = 0; k < 3; k++) do_read(64'(500 + k));
        rd_idle();

        for (int t = 0; t < 40; t++) begin
            if (t % 5 == 0) do_read({$urandom, $urandom});
            else            do_read(64'($urandom_range(0, 1023)));
        end
        rd_idle();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 80'(exp_q.size()), 80'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
